// File: rtl/game_pkg.sv
// Game-wide encodings shared by the VGA compositing path and the game state machine.
package game_pkg;

  localparam int RGB_W = 12;

  typedef enum logic [1:0] {
    GAME_INITIAL = 2'b00,
    GAME_RUNNING = 2'b01,
    GAME_OVER    = 2'b10,
    GAME_SUCCESS = 2'b11
  } game_state_e;

endpackage

// File: rtl/sprite_priority_sel.sv
// Combinational sprite priority: picks the colour of the lowest-index opaque channel.
module sprite_priority_sel #(
  parameter int N_SPR = 4,
  parameter int COL_W = 12
) (
  input  logic [N_SPR-1:0]       opaque_i,
  input  logic [N_SPR*COL_W-1:0] spr_col_i,
  output logic                   any_o,
  output logic [COL_W-1:0]       col_o
);

  // Walk from the lowest priority upward so the last hit seen is the lowest index.
  always_comb begin
    any_o = 1'b0;
    col_o = '0;
    for (int k = N_SPR - 1; k >= 0; k--) begin
      if (opaque_i[k]) begin
        any_o = 1'b1;
        col_o = spr_col_i[k*COL_W +: COL_W];
      end
    end
  end

endmodule

// File: rtl/sprite_layer_mixer.sv
// Two-stage per-pixel compositor: sprite priority over background, game-state screen modes,
// and per-frame player collision detection published on each scan return to the origin.
module sprite_layer_mixer
  import game_pkg::*;
#(
  parameter int               N_SPR    = 4,
  parameter int               COL_W    = RGB_W,
  parameter int               BG_W     = 16,
  parameter int               X_W      = 10,
  parameter int               Y_W      = 9,
  parameter logic [COL_W-1:0] TRANSP   = 12'h000,
  parameter logic [BG_W-1:0]  BG_KEY   = 16'hFFFF,
  parameter logic [COL_W-1:0] INIT_COL = 12'hF00,
  parameter logic [COL_W-1:0] WIN_COL  = 12'h00F
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             game_state,
  input  logic [X_W-1:0]         pix_x,
  input  logic [Y_W-1:0]         pix_y,
  input  logic [N_SPR-1:0]       spr_en,
  input  logic [N_SPR*COL_W-1:0] spr_col,
  input  logic [BG_W-1:0]        bg_col,
  output logic [COL_W-1:0]       vga_data,
  output logic [N_SPR-1:0]       coll_mask,
  output logic                   coll_any,
  output logic                   frame_tick
);

  logic [N_SPR-1:0] opaque_d;
  logic             win_any_d;
  logic [COL_W-1:0] win_col_d;

  for (genvar gi = 0; gi < N_SPR; gi++) begin : g_opaque
    assign opaque_d[gi] = spr_en[gi] && (spr_col[gi*COL_W +: COL_W] != TRANSP);
  end

  sprite_priority_sel #(.N_SPR(N_SPR), .COL_W(COL_W)) u_sel (
    .opaque_i  (opaque_d),
    .spr_col_i (spr_col),
    .any_o     (win_any_d),
    .col_o     (win_col_d)
  );

  // Stage 1 registers, plus the previous stage-1 coordinates for origin edge detection.
  logic [X_W-1:0]   x_q, x_prev_q;
  logic [Y_W-1:0]   y_q, y_prev_q;
  game_state_e      state_q;
  logic [N_SPR-1:0] opaque_q;
  logic             win_any_q;
  logic [COL_W-1:0] win_col_q;
  logic [BG_W-1:0]  bg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      x_prev_q  <= '0;
      y_prev_q  <= '0;
      state_q   <= GAME_INITIAL;
      opaque_q  <= '0;
      win_any_q <= 1'b0;
      win_col_q <= '0;
      bg_q      <= '0;
    end else begin
      x_q       <= pix_x;
      y_q       <= pix_y;
      x_prev_q  <= x_q;
      y_prev_q  <= y_q;
      state_q   <= game_state_e'(game_state);
      opaque_q  <= opaque_d;
      win_any_q <= win_any_d;
      win_col_q <= win_col_d;
      bg_q      <= bg_col;
    end
  end

  logic [COL_W-1:0] bg_top;
  logic [COL_W-1:0] vga_d;
  logic [N_SPR-1:0] hit;
  logic             boundary;
  logic [N_SPR-1:0] acc_q, acc_d;
  logic [N_SPR-1:0] mask_q, mask_d;
  logic             any_q, any_d;
  logic             tick_q;

  assign bg_top   = (bg_q == BG_KEY) ? '0 : bg_q[BG_W-1 -: COL_W];
  assign boundary = (x_q == '0) && (y_q == '0) && !((x_prev_q == '0) && (y_prev_q == '0));

  always_comb begin
    vga_d = bg_top;
    case (state_q)
      GAME_INITIAL: vga_d = INIT_COL;
      GAME_SUCCESS: vga_d = WIN_COL;
      GAME_OVER:    vga_d = bg_top;
      default:      vga_d = win_any_q ? win_col_q : bg_top;
    endcase
  end

  // The origin pixel's own hit starts the new frame rather than closing the old one.
  always_comb begin
    hit    = '0;
    acc_d  = '0;
    mask_d = mask_q;
    any_d  = any_q;
    if (state_q == GAME_RUNNING && opaque_q[0]) hit = {opaque_q[N_SPR-1:1], 1'b0};
    if (boundary) begin
      mask_d = acc_q;
      any_d  = |acc_q;
      acc_d  = hit;
    end else if (state_q == GAME_RUNNING) begin
      acc_d  = acc_q | hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_data <= '0;
      acc_q    <= '0;
      mask_q   <= '0;
      any_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      vga_data <= vga_d;
      acc_q    <= acc_d;
      mask_q   <= mask_d;
      any_q    <= any_d;
      tick_q   <= boundary;
    end
  end

  assign coll_mask  = mask_q;
  assign coll_any   = any_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Self-checking bench for sprite_layer_mixer: directed scenarios plus randomized scan
// compared against a frame-level reference model of the compositor.
module tb_sprite_layer_mixer;

  localparam logic [11:0] T   = 12'h000;
  localparam logic [1:0]  INI = 2'b00;
  localparam logic [1:0]  RUN = 2'b01;
  localparam logic [1:0]  OVR = 2'b10;
  localparam logic [1:0]  SUC = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  game_state = 2'b00;
  logic [9:0]  pix_x = '0;
  logic [8:0]  pix_y = '0;
  logic [3:0]  spr_en = '0;
  logic [47:0] spr_col = '0;
  logic [15:0] bg_col = '0;
  logic [11:0] vga_data;
  logic [3:0]  coll_mask;
  logic        coll_any;
  logic        frame_tick;

  sprite_layer_mixer dut (
    .clk(clk), .rst(rst), .game_state(game_state), .pix_x(pix_x), .pix_y(pix_y),
    .spr_en(spr_en), .spr_col(spr_col), .bg_col(bg_col), .vga_data(vga_data),
    .coll_mask(coll_mask), .coll_any(coll_any), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [1:0]  st;
    int          x;
    int          y;
    logic [3:0]  en;
    logic [11:0] c [4];
    logic [15:0] bg;
  } stim_t;

  typedef struct {
    int          tag;
    bit          chk;
    logic [11:0] vga;
    logic [3:0]  mask;
    logic        any;
    logic        tick;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  // Reference model state: channels the player touched this frame, last published set,
  // and whether the previous pixel was the origin.
  bit [3:0] m_seen;
  bit [3:0] m_pub;
  bit       m_last_origin;

  function automatic stim_t mk(int tag, logic [1:0] st, int x, int y, logic [3:0] en,
                               logic [11:0] c0, logic [11:0] c1, logic [11:0] c2,
                               logic [11:0] c3, logic [15:0] bg);
    stim_t s;
    s.tag = tag; s.st = st; s.x = x; s.y = y; s.en = en;
    s.c[0] = c0; s.c[1] = c1; s.c[2] = c2; s.c[3] = c3; s.bg = bg;
    return s;
  endfunction

  function automatic logic [11:0] ref_vga(stim_t s);
    logic [11:0] back;
    if (s.st == INI) return 12'hF00;
    if (s.st == SUC) return 12'h00F;
    back = (s.bg == 16'hFFFF) ? 12'h000 : s.bg[15:4];
    if (s.st == OVR) return back;
    for (int k = 0; k < 4; k++)
      if (s.en[k] && s.c[k] != T) return s.c[k];
    return back;
  endfunction

  task automatic model_reset();
    exp_t d;
    m_seen = '0; m_pub = '0; m_last_origin = 1'b1;
    exp_q.delete();
    d.tag = -1; d.chk = 1'b0; d.vga = '0; d.mask = '0; d.any = 1'b0; d.tick = 1'b0;
    exp_q.push_back(d);
  endtask

  // Applies one pixel at the falling edge; hands back the expectation for the pixel
  // whose result is visible right now (two pixels earlier).
  task automatic step(input stim_t s, output bit v, output exp_t e);
    exp_t n;
    bit   origin, player;
    @(negedge clk);
    v = 1'b0;
    e = '{default: 0};
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      v = 1'b1;
    end
    rst = 1'b0;
    game_state = s.st;
    pix_x = s.x[9:0];
    pix_y = s.y[8:0];
    spr_en = s.en;
    spr_col = {s.c[3], s.c[2], s.c[1], s.c[0]};
    bg_col = s.bg;

    n.tag = s.tag; n.chk = 1'b1; n.vga = ref_vga(s);
    origin = (s.x == 0 && s.y == 0);
    n.tick = origin && !m_last_origin;
    m_last_origin = origin;
    if (n.tick) begin
      m_pub = m_seen;
      m_seen = '0;
    end
    if (s.st != RUN) m_seen = '0;
    player = (s.st == RUN) && s.en[0] && (s.c[0] != T);
    for (int k = 1; k < 4; k++)
      if (player && s.en[k] && s.c[k] != T) m_seen[k] = 1'b1;
    n.mask = m_pub; n.any = |m_pub;
    exp_q.push_back(n);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; game_state = RUN; pix_x = 10'd5; pix_y = 9'd7; spr_en = 4'hF;
    spr_col = 48'h123_456_789_ABC; bg_col = 16'h1234;
    repeat (2) @(negedge clk);
    total++; if (vga_data !== 12'h000) begin bad++; $display("FAIL reset_vga got=%h want=000", vga_data); end
    total++; if (coll_mask !== 4'h0) begin bad++; $display("FAIL reset_mask got=%b want=0000", coll_mask); end
    total++; if (coll_any !== 1'b0) begin bad++; $display("FAIL reset_any got=%b want=0", coll_any); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", frame_tick); end
    model_reset();
  endtask

  task automatic test_priority();
    stim_t s[$]; bit v; exp_t e;
    s.push_back(mk(1, RUN, 10, 10, 4'b0110, T, 12'h0F0, 12'h00F, T, 16'h1234));
    s.push_back(mk(2, RUN, 11, 10, 4'b0100, T, 12'h0F0, 12'h00F, T, 16'h1234));
    s.push_back(mk(0, RUN, 12, 10, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(0, RUN, 13, 10, 4'b0000, T, T, T, T, 16'h0000));
    foreach (s[i]) begin
      step(s[i], v, e);
      if (v && e.chk) begin
        total++; if (vga_data !== e.vga) begin bad++; $display("FAIL prio_vga tag=%0d got=%h want=%h", e.tag, vga_data, e.vga); end
        total++; if ({coll_mask, coll_any, frame_tick} !== {e.mask, e.any, e.tick}) begin bad++;
          $display("FAIL prio_coll tag=%0d got=%b/%b/%b want=%b/%b/%b", e.tag, coll_mask, coll_any, frame_tick, e.mask, e.any, e.tick); end
        if (e.tag == 1) begin total++; if (vga_data !== 12'h0F0) begin bad++; $display("FAIL prio_ch1 got=%h want=0f0", vga_data); end end
        if (e.tag == 2) begin total++; if (vga_data !== 12'h00F) begin bad++; $display("FAIL prio_ch2 got=%h want=00f", vga_data); end end
      end
    end
  endtask

  task automatic test_background();
    stim_t s[$]; bit v; exp_t e;
    s.push_back(mk(1, RUN, 20, 10, 4'b1111, T, T, T, T, 16'hFFFF));
    s.push_back(mk(2, RUN, 21, 10, 4'b1111, T, T, T, T, 16'h1234));
    s.push_back(mk(3, OVR, 22, 10, 4'b0010, T, 12'h0F0, T, T, 16'h1234));
    s.push_back(mk(0, RUN, 23, 10, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(0, RUN, 24, 10, 4'b0000, T, T, T, T, 16'h0000));
    foreach (s[i]) begin
      step(s[i], v, e);
      if (v && e.chk) begin
        total++; if (vga_data !== e.vga) begin bad++; $display("FAIL bg_vga tag=%0d got=%h want=%h", e.tag, vga_data, e.vga); end
        total++; if ({coll_mask, coll_any, frame_tick} !== {e.mask, e.any, e.tick}) begin bad++;
          $display("FAIL bg_coll tag=%0d got=%b/%b/%b want=%b/%b/%b", e.tag, coll_mask, coll_any, frame_tick, e.mask, e.any, e.tick); end
        if (e.tag == 1) begin total++; if (vga_data !== 12'h000) begin bad++; $display("FAIL bg_key got=%h want=000", vga_data); end end
        if (e.tag == 2 || e.tag == 3) begin total++;
          if (vga_data !== 12'h123) begin bad++; $display("FAIL bg_upper tag=%0d got=%h want=123", e.tag, vga_data); end end
      end
    end
  endtask

  task automatic test_collision();
    stim_t s[$]; bit v; exp_t e;
    s.push_back(mk(0, RUN, 99, 50, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(0, RUN, 100, 50, 4'b0101, 12'hABC, T, 12'h321, T, 16'h0000));
    s.push_back(mk(0, RUN, 101, 50, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(10, RUN, 0, 0, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(11, RUN, 1, 0, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(0, RUN, 2, 0, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(12, RUN, 0, 0, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(0, RUN, 1, 0, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(0, RUN, 2, 0, 4'b0000, T, T, T, T, 16'h0000));
    foreach (s[i]) begin
      step(s[i], v, e);
      if (v && e.chk) begin
        total++; if (vga_data !== e.vga) begin bad++; $display("FAIL coll_vga tag=%0d got=%h want=%h", e.tag, vga_data, e.vga); end
        total++; if ({coll_mask, coll_any, frame_tick} !== {e.mask, e.any, e.tick}) begin bad++;
          $display("FAIL coll_model tag=%0d got=%b/%b/%b want=%b/%b/%b", e.tag, coll_mask, coll_any, frame_tick, e.mask, e.any, e.tick); end
        if (e.tag == 10) begin total++; if ({coll_mask, coll_any, frame_tick} !== 6'b0100_1_1) begin bad++;
          $display("FAIL coll_publish got=%b/%b/%b want=0100/1/1", coll_mask, coll_any, frame_tick); end end
        if (e.tag == 11) begin total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL coll_pulse got=%b want=0", frame_tick); end end
        if (e.tag == 12) begin total++; if ({coll_mask, coll_any, frame_tick} !== 6'b0000_0_1) begin bad++;
          $display("FAIL coll_clean got=%b/%b/%b want=0000/0/1", coll_mask, coll_any, frame_tick); end end
      end
    end
  endtask

  task automatic test_origin_corner();
    stim_t s[$]; bit v; exp_t e;
    s.push_back(mk(0, RUN, 5, 5, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(20, RUN, 0, 0, 4'b0011, 12'h777, 12'h888, T, T, 16'h0000));
    for (int k = 21; k <= 24; k++) s.push_back(mk(k, RUN, 0, 0, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(0, RUN, 1, 0, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(0, RUN, 2, 0, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(25, RUN, 0, 0, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(0, RUN, 1, 0, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(0, RUN, 2, 0, 4'b0000, T, T, T, T, 16'h0000));
    foreach (s[i]) begin
      step(s[i], v, e);
      if (v && e.chk) begin
        total++; if (vga_data !== e.vga) begin bad++; $display("FAIL corner_vga tag=%0d got=%h want=%h", e.tag, vga_data, e.vga); end
        total++; if ({coll_mask, coll_any, frame_tick} !== {e.mask, e.any, e.tick}) begin bad++;
          $display("FAIL corner_model tag=%0d got=%b/%b/%b want=%b/%b/%b", e.tag, coll_mask, coll_any, frame_tick, e.mask, e.any, e.tick); end
        if (e.tag == 20) begin total++; if ({coll_mask, frame_tick} !== 5'b0000_1) begin bad++;
          $display("FAIL corner_defer got=%b/%b want=0000/1", coll_mask, frame_tick); end end
        if (e.tag >= 21 && e.tag <= 24) begin total++; if (frame_tick !== 1'b0) begin bad++;
          $display("FAIL corner_stall tag=%0d got=%b want=0", e.tag, frame_tick); end end
        if (e.tag == 25) begin total++; if ({coll_mask, coll_any, frame_tick} !== 6'b0010_1_1) begin bad++;
          $display("FAIL corner_next got=%b/%b/%b want=0010/1/1", coll_mask, coll_any, frame_tick); end end
      end
    end
  endtask

  task automatic test_states();
    stim_t s[$]; bit v; exp_t e;
    s.push_back(mk(30, INI, 7, 7, 4'b1111, 12'h111, 12'h222, T, T, 16'h1234));
    s.push_back(mk(31, SUC, 8, 7, 4'b1111, 12'h111, 12'h222, T, T, 16'h1234));
    s.push_back(mk(0, RUN, 3, 3, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(32, RUN, 0, 0, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(33, RUN, 1, 0, 4'b1001, 12'h444, T, T, 12'h555, 16'h0000));
    s.push_back(mk(34, OVR, 2, 0, 4'b0000, T, T, T, T, 16'h5678));
    s.push_back(mk(0, RUN, 3, 0, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(35, RUN, 0, 0, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(0, RUN, 1, 0, 4'b0000, T, T, T, T, 16'h0000));
    s.push_back(mk(0, RUN, 2, 0, 4'b0000, T, T, T, T, 16'h0000));
    foreach (s[i]) begin
      step(s[i], v, e);
      if (v && e.chk) begin
        total++; if (vga_data !== e.vga) begin bad++; $display("FAIL state_vga tag=%0d got=%h want=%h", e.tag, vga_data, e.vga); end
        total++; if ({coll_mask, coll_any, frame_tick} !== {e.mask, e.any, e.tick}) begin bad++;
          $display("FAIL state_coll tag=%0d got=%b/%b/%b want=%b/%b/%b", e.tag, coll_mask, coll_any, frame_tick, e.mask, e.any, e.tick); end
        if (e.tag == 30) begin total++; if (vga_data !== 12'hF00) begin bad++; $display("FAIL state_init got=%h want=f00", vga_data); end end
        if (e.tag == 31) begin total++; if (vga_data !== 12'h00F) begin bad++; $display("FAIL state_win got=%h want=00f", vga_data); end end
        if (e.tag == 35) begin total++; if ({coll_mask, coll_any, frame_tick} !== 6'b0000_0_1) begin bad++;
          $display("FAIL state_over_clear got=%b/%b/%b want=0000/0/1", coll_mask, coll_any, frame_tick); end end
      end
    end
  endtask

  task automatic test_random();
    stim_t s; bit v; exp_t e;
    int x = 1, y = 0;
    for (int i = 0; i < 402; i++) begin
      s.tag = 100 + i;
      s.st = ($urandom_range(0, 9) < 7) ? RUN : 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) != 0) begin
        x++;
        if (x == 12) begin x = 0; y = (y == 2) ? 0 : y + 1; end
      end
      s.x = x; s.y = y;
      s.en = (i >= 400) ? 4'b0000 : 4'($urandom);
      for (int k = 0; k < 4; k++) s.c[k] = ($urandom_range(0, 2) == 0) ? T : 12'($urandom);
      s.bg = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      step(s, v, e);
      if (v && e.chk) begin
        total++; if (vga_data !== e.vga) begin bad++; $display("FAIL rand_vga tag=%0d got=%h want=%h", e.tag, vga_data, e.vga); end
        total++; if ({coll_mask, coll_any, frame_tick} !== {e.mask, e.any, e.tick}) begin bad++;
          $display("FAIL rand_coll tag=%0d got=%b/%b/%b want=%b/%b/%b", e.tag, coll_mask, coll_any, frame_tick, e.mask, e.any, e.tick); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_background();
    test_collision();
    test_origin_corner();
    test_states();
    test_random();
    test_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
